// File: rtl/hs_fifo_responder.sv
// Elastic req/ack buffer: initiator toward the upstream link, single-pulse responder toward the
// downstream link, with a circular store of 1<<addr_width words in between.
module hs_fifo_responder #(
   parameter int                    data_width = 32,
   parameter int                    addr_width = 2,
   parameter logic [data_width-1:0] init_value = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  req_l,
   input  logic                  ack_l,
   input  logic [data_width-1:0] din,
   input  logic                  req_r,
   output logic                  ack_r,
   output logic [data_width-1:0] dout,
   output logic [addr_width:0]   count,
   output logic                  err
);

   localparam int                DEPTH   = 1 << addr_width;
   localparam logic [addr_width:0] DEPTH_C = (addr_width + 1)'(DEPTH);

   logic [data_width-1:0] mem [DEPTH];

   logic                  req_l_q, req_l_d;
   logic                  ack_r_q, ack_r_d;
   logic [data_width-1:0] dout_q, dout_d;
   logic [addr_width:0]   count_q, count_d;
   logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
   logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
   logic                  err_q, err_d;
   logic                  wr_en, rd_en;

   always_comb begin
      wr_en    = req_l_q & ack_l;
      rd_en    = req_r & ~ack_r_q & (count_q != '0);
      req_l_d  = req_l_q;
      ack_r_d  = rd_en;
      dout_d   = dout_q;
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      err_d    = err_q | (ack_l & ~req_l_q);

      // A request is only raised with room to spare; while it is pending the count cannot grow.
      if (wr_en) begin
         req_l_d  = 1'b0;
         wr_ptr_d = wr_ptr_q + 1'b1;
      end else if (!req_l_q && (count_q < DEPTH_C)) begin
         req_l_d  = 1'b1;
      end

      if (rd_en) begin
         dout_d   = mem[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_l_q  <= 1'b0;
         ack_r_q  <= 1'b0;
         dout_q   <= init_value;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         err_q    <= 1'b0;
      end else begin
         req_l_q  <= req_l_d;
         ack_r_q  <= ack_r_d;
         dout_q   <= dout_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         err_q    <= err_d;
      end
   end

   // Storage carries no reset; the pointers and count alone decide what is valid.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         mem[wr_ptr_q] <= din;
      end
   end

   assign req_l = req_l_q;
   assign ack_r = ack_r_q;
   assign dout  = dout_q;
   assign count = count_q;
   assign err   = err_q;

endmodule
